// File: rtl/operand_fetch.sv
// Operand-fetch stage sitting in front of the 32x8 register file.
//
// Accepts decoded read requests over valid/ready and drives the register
// file read controls for one cycle. On the next edge it captures the
// returned bytes and pushes {op_a, op_b, tag} into a 2-entry output FIFO.
// The FIFO head drives the execute-stage interface.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   flush             synchronous discard of in-flight and buffered operands
//   in_valid/in_ready request handshake
//   in_mode           00 none, 01 A, 10 A and B, 11 pair (A, A+1)
//   in_src_a/b, in_tag request fields
//   rf_rd_en/addr     register file read controls (slot 0 low, slot 1 high)
//   rf_data_out       register file read data (slot 0 low byte)
//   out_valid/ready   result handshake
//   out_op_a/b, out_tag head FIFO entry
module operand_fetch #(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [4:0]       in_src_a,
    input  logic [4:0]       in_src_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [1:0]       rf_rd_en,
    output logic [9:0]       rf_rd_addr,
    input  logic [15:0]      rf_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_op_a,
    output logic [7:0]       out_op_b,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] Depth = 2'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e state_q, state_d;
    logic   inflight;

    logic [1:0]       rf_rd_en_q;
    logic [9:0]       rf_rd_addr_q;
    logic [1:0]       mode_q;
    logic [TAG_W-1:0] tag_q;

    logic [7:0]       fifo_a_q   [2];
    logic [7:0]       fifo_b_q   [2];
    logic [TAG_W-1:0] fifo_tag_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;

    // Last head values, shown while the FIFO is empty.
    logic [7:0]       hold_a_q, hold_b_q;
    logic [TAG_W-1:0] hold_tag_q;

    logic       accept, push, pop;
    logic [1:0] occupancy;
    logic [7:0] cap_a, cap_b;
    logic [1:0] dec_en;
    logic [4:0] dec_slot1;

    // ------------------------------------------------------------------
    // Handshake and credit
    // ------------------------------------------------------------------
    always_comb begin
        occupancy = count_q + {1'b0, inflight};
        in_ready  = 1'b0;
        if (!reset && !flush) begin
            // A pop in this cycle frees the slot the new request will need.
            in_ready = (occupancy < Depth) ||
                       ((occupancy == Depth) && out_valid && out_ready);
        end
        accept = in_valid && in_ready;
        pop    = out_valid && out_ready;
        push   = inflight && !flush;
    end

    // ------------------------------------------------------------------
    // Issue-side FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRead;
            StRead: state_d = accept ? StRead : StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        inflight = (state_q == StRead);
    end

    // ------------------------------------------------------------------
    // Request decode and register file controls
    // ------------------------------------------------------------------
    always_comb begin
        dec_en    = 2'b00;
        dec_slot1 = in_src_b;
        unique case (in_mode)
            2'b00: dec_en = 2'b00;
            2'b01: dec_en = 2'b01;
            2'b10: dec_en = 2'b11;
            2'b11: begin
                dec_en    = 2'b11;
                dec_slot1 = in_src_a + 5'd1;  // wraps 31 -> 0
            end
            default: dec_en = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_rd_en_q   <= 2'b00;
            rf_rd_addr_q <= 10'd0;
            mode_q       <= 2'b00;
            tag_q        <= '0;
        end else if (accept) begin
            rf_rd_en_q   <= dec_en;
            rf_rd_addr_q <= {dec_slot1, in_src_a};
            mode_q       <= in_mode;
            tag_q        <= in_tag;
        end else begin
            // Address holds when idle; enable is a one-cycle pulse.
            rf_rd_en_q <= 2'b00;
        end
    end

    assign rf_rd_en   = rf_rd_en_q;
    assign rf_rd_addr = rf_rd_addr_q;

    // ------------------------------------------------------------------
    // Capture and output FIFO
    // ------------------------------------------------------------------
    always_comb begin
        cap_a = (mode_q == 2'b00) ? 8'h00 : rf_data_out[7:0];
        cap_b = mode_q[1] ? rf_data_out[15:8] : 8'h00;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (flush) count_d = 2'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_a_q[i]   <= 8'h00;
                fifo_b_q[i]   <= 8'h00;
                fifo_tag_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_a_q[wr_ptr_q]   <= cap_a;
                    fifo_b_q[wr_ptr_q]   <= cap_b;
                    fifo_tag_q[wr_ptr_q] <= tag_q;
                    wr_ptr_q             <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_a_q   <= 8'h00;
            hold_b_q   <= 8'h00;
            hold_tag_q <= '0;
        end else if (out_valid) begin
            hold_a_q   <= out_op_a;
            hold_b_q   <= out_op_b;
            hold_tag_q <= out_tag;
        end
    end

    always_comb begin
        out_valid = (count_q != 2'd0);
        if (out_valid) begin
            out_op_a = fifo_a_q[rd_ptr_q];
            out_op_b = fifo_b_q[rd_ptr_q];
            out_tag  = fifo_tag_q[rd_ptr_q];
        end else begin
            out_op_a = hold_a_q;
            out_op_b = hold_b_q;
            out_tag  = hold_tag_q;
        end
    end

endmodule
